// File: rtl/hls_deadlock_channel_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hls_deadlock_channel_monitor: reports AXIS/FIFO stalls held THRESH cycles |
// | while some sub-instance is busy. Option: HLS_DEADLOCK_MONITOR_STICKY_EN.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hls_deadlock_channel_monitor #(
  parameter int  NUM_AXIS = 3,
  parameter int  NUM_INST = 10,
  parameter int  THRESH   = 1,
  parameter int  CNT_W    = 8,
  localparam int IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_AXIS-1:0] axis_mask,
  input  logic                clear,
  output logic                block,
  output logic [IDX_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    event_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  localparam logic [15:0] THRESH_C = 16'(THRESH);

  state_t                  state_q, state_d;
  logic [15:0]             run_cnt_q, run_cnt_d;
  logic                    block_q, block_d;
  logic [IDX_W-1:0]        first_idx_q, first_idx_d;
  logic [CNT_W-1:0]        event_count_q, event_count_d;

  logic [NUM_AXIS-1:0]     active;
  logic                    raw;
  logic                    enter;
  logic [IDX_W-1:0]        low_idx;

  // A stall only counts while at least one sub-instance is still working.
  assign active = axis_block_sigs & ~axis_mask;
  assign raw    = (|active) & ~(&inst_idle_sigs);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (active[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    first_idx_d   = first_idx_q;
    event_count_d = event_count_q;
    enter         = 1'b0;

    if (clear) begin
      state_d       = IDLE;
      run_cnt_d     = '0;
      first_idx_d   = '0;
      event_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (raw) begin
            run_cnt_d = 16'd1;
            if (THRESH_C == 16'd1) enter   = 1'b1;
            else                   state_d = SUSPECT;
          end else begin
            run_cnt_d = '0;
          end
        end
        SUSPECT: begin
          if (raw) begin
            run_cnt_d = run_cnt_q + 16'd1;
            if (run_cnt_q + 16'd1 == THRESH_C) enter = 1'b1;
          end else begin
            state_d   = IDLE;
            run_cnt_d = '0;
          end
        end
        BLOCKED: begin
`ifdef HLS_DEADLOCK_MONITOR_STICKY_EN
          state_d = BLOCKED;
`else
          if (!raw) begin
            state_d   = IDLE;
            run_cnt_d = '0;
          end
`endif
        end
        default: begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end
      endcase

      if (enter) begin
        state_d     = BLOCKED;
        first_idx_d = low_idx;
        if (event_count_q != {CNT_W{1'b1}}) event_count_d = event_count_q + CNT_W'(1);
      end
    end

    block_d = (state_d == BLOCKED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      run_cnt_q     <= '0;
      block_q       <= 1'b0;
      first_idx_q   <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      block_q       <= block_d;
      first_idx_q   <= first_idx_d;
      event_count_q <= event_count_d;
    end
  end

  assign block       = block_q;
  assign first_idx   = first_idx_q;
  assign event_count = event_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_deadlock_channel_monitor.sv
`default_nettype none
// Bench for hls_deadlock_channel_monitor: three instances (THRESH 1/4/2) share
// one stimulus stream and are checked against a streak-based reference model.
module tb_hls_deadlock_channel_monitor;

  localparam int NA = 3;
  localparam int NI = 10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [NA-1:0] axis_block_sigs = '0;
  logic [NA-1:0] axis_mask = '0;
  logic [NI-1:0] inst_idle_sigs = '0;

  logic       blk0, blk1, blk2;
  logic [1:0] idx0, idx1, idx2;
  logic [1:0] cnt0;
  logic [7:0] cnt1, cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hls_deadlock_channel_monitor #(.NUM_AXIS(NA), .NUM_INST(NI), .THRESH(1), .CNT_W(2)) u_d0 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .axis_mask(axis_mask), .clear(clear),
    .block(blk0), .first_idx(idx0), .event_count(cnt0));

  hls_deadlock_channel_monitor #(.NUM_AXIS(NA), .NUM_INST(NI), .THRESH(4), .CNT_W(8)) u_d1 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .axis_mask(axis_mask), .clear(clear),
    .block(blk1), .first_idx(idx1), .event_count(cnt1));

  hls_deadlock_channel_monitor #(.NUM_AXIS(NA), .NUM_INST(NI), .THRESH(2), .CNT_W(8)) u_d2 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .axis_mask(axis_mask), .clear(clear),
    .block(blk2), .first_idx(idx2), .event_count(cnt2));

  // Reference model: a monitor reports block once the current run of
  // consecutive stalled cycles has reached THRESH.
  int thr  [3] = '{1, 4, 2};
  int cmax [3] = '{3, 255, 255};
  int streak [3];
  bit mblk   [3];
  int midx   [3];
  int mcnt   [3];

  always @(posedge clock or negedge reset_n) begin
    bit m_raw;
    bit any;
    bit nb;
    int low;
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        streak[k] = 0; mblk[k] = 0; midx[k] = 0; mcnt[k] = 0;
      end
    end else begin
      any = 0;
      low = 0;
      for (int i = NA - 1; i >= 0; i--) begin
        if (axis_block_sigs[i] && !axis_mask[i]) begin
          any = 1;
          low = i;
        end
      end
      m_raw = any && (inst_idle_sigs != {NI{1'b1}});
      for (int k = 0; k < 3; k++) begin
        if (clear) begin
          streak[k] = 0; mblk[k] = 0; midx[k] = 0; mcnt[k] = 0;
        end else begin
          streak[k] = m_raw ? ((streak[k] < 1000000) ? streak[k] + 1 : streak[k]) : 0;
`ifdef HLS_DEADLOCK_MONITOR_STICKY_EN
          nb = mblk[k] || (streak[k] >= thr[k]);
`else
          nb = (streak[k] >= thr[k]);
`endif
          if (nb && !mblk[k]) begin
            midx[k] = low;
            mcnt[k] = (mcnt[k] < cmax[k]) ? mcnt[k] + 1 : mcnt[k];
          end
          mblk[k] = nb;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("m0.block", int'(blk0), int'(mblk[0]));
    chk("m0.first_idx", int'(idx0), midx[0]);
    chk("m0.event_count", int'(cnt0), mcnt[0]);
    chk("m1.block", int'(blk1), int'(mblk[1]));
    chk("m1.first_idx", int'(idx1), midx[1]);
    chk("m1.event_count", int'(cnt1), mcnt[1]);
    chk("m2.block", int'(blk2), int'(mblk[2]));
    chk("m2.first_idx", int'(idx2), midx[2]);
    chk("m2.event_count", int'(cnt2), mcnt[2]);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    axis_block_sigs = '0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("reset.block", int'(blk0), 0);
    chk("reset.event_count", int'(cnt1), 0);
    chk("reset.first_idx", int'(idx2), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // THRESH=1 one-cycle latency, THRESH=2 and THRESH=4 from the same run
    axis_block_sigs = 3'b010;
    tick();
    chk("t1.block", int'(blk0), 1);
    chk("t1.first_idx", int'(idx0), 1);
    chk("t1.event_count", int'(cnt0), 1);
    chk("t2.block_early", int'(blk2), 0);
    tick();
    chk("t2.block", int'(blk2), 1);
    tick();
    chk("t4.block_early", int'(blk1), 0);
    tick();
    chk("t4.block", int'(blk1), 1);

    // clear wins over a live stall
    clear = 1'b1;
    tick();
    chk("clear.block", int'(blk0), 0);
    chk("clear.event_count", int'(cnt0), 0);
    clear = 1'b0;
    axis_block_sigs = '0;
    tick();

    // one low cycle restarts the run
    axis_block_sigs = 3'b001;
    repeat (3) begin tick(); chk("restart.run1", int'(blk1), 0); end
    axis_block_sigs = '0;
    tick();
    chk("restart.gap", int'(blk1), 0);
    axis_block_sigs = 3'b001;
    repeat (3) begin tick(); chk("restart.run2", int'(blk1), 0); end
    tick();
    chk("restart.block", int'(blk1), 1);

    // masked lowest channel shifts first_idx; fully masked never blocks
    do_clear();
    axis_block_sigs = 3'b101;
    axis_mask = 3'b001;
    tick(); tick();
    chk("mask.block", int'(blk2), 1);
    chk("mask.first_idx", int'(idx2), 2);
    do_clear();
    axis_block_sigs = 3'b101;
    axis_mask = 3'b101;
    repeat (5) tick();
    chk("mask.all", int'(blk2), 0);
    axis_block_sigs = 3'b010;
    axis_mask = 3'b010;
    repeat (2) tick();
    chk("mask.same_cycle", int'(blk0), 0);

    // all instances idle is never a deadlock
    axis_mask = '0;
    axis_block_sigs = 3'b111;
    inst_idle_sigs = {NI{1'b1}};
    repeat (6) tick();
    chk("allidle.block", int'(blk0), 0);
    chk("allidle.block4", int'(blk1), 0);
    inst_idle_sigs = 10'b1111111110;
    axis_block_sigs = '0;
    tick();

    // exit from BLOCKED on a single low cycle
    axis_block_sigs = 3'b001;
    tick();
    chk("exit.enter", int'(blk0), 1);
    axis_block_sigs = '0;
    tick();
`ifdef HLS_DEADLOCK_MONITOR_STICKY_EN
    chk("exit.sticky", int'(blk0), 1);
`else
    chk("exit.nonsticky", int'(blk0), 0);
`endif
    tick();
    do_clear();
    chk("exit.clear_block", int'(blk0), 0);
    chk("exit.clear_count", int'(cnt0), 0);

    // 2-bit counter saturates after five entries
    repeat (5) begin
      axis_block_sigs = 3'b100;
      tick();
      axis_block_sigs = '0;
      tick();
    end
`ifndef HLS_DEADLOCK_MONITOR_STICKY_EN
    chk("sat.event_count", int'(cnt0), 3);
`endif

    // asynchronous reset while blocked
    axis_block_sigs = 3'b001;
    tick();
    chk("areset.pre", int'(blk0), 1);
    reset_n = 1'b0;
    #1;
    chk("areset.block", int'(blk0), 0);
    chk("areset.event_count", int'(cnt0), 0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("areset.resume", int'(blk0), 1);
    chk("areset.resume_count", int'(cnt0), 1);
    axis_block_sigs = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hls_deadlock_channel_monitor.md
HLS_DEADLOCK_CHANNEL_MONITOR -- requirements
Module: hls_deadlock_channel_monitor

Interface
REQ-001 Parameter NUM_AXIS, default 3: number of monitored AXIS/FIFO block channels, range 1..32.
REQ-002 Parameter NUM_INST, default 10: number of sub-instance idle inputs, range 1..64.
REQ-003 Parameter THRESH, default 1: consecutive raw-block cycles required before block is reported, range 1..2^16-1.
REQ-004 Parameter CNT_W, default 8: width of event_count.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 axis_block_sigs  input  NUM_AXIS  per-channel blocked indication, bit i = channel i.
REQ-008 inst_idle_sigs  input  NUM_INST  per-instance idle indication.
REQ-009 axis_mask  input  NUM_AXIS  1 = channel ignored.
REQ-010 clear  input  1  synchronous clear of detection state and counters.
REQ-011 block  output  1  registered deadlock report.
REQ-012 first_idx  output  max(1,clog2(NUM_AXIS))  channel index captured at last BLOCKED entry.
REQ-013 event_count  output  CNT_W  number of BLOCKED entries since reset/clear.

Function
REQ-014 raw = OR over i of (axis_block_sigs[i] AND NOT axis_mask[i]), AND NOT (AND of all inst_idle_sigs); all-idle never counts as blocked.
REQ-015 FSM states IDLE, SUSPECT, BLOCKED; run counter run_cnt, 16 bits, saturating at THRESH.
REQ-016 IDLE: raw=1 -> run_cnt=1; if THRESH=1 go BLOCKED, else go SUSPECT; raw=0 -> stay IDLE, run_cnt=0.
REQ-017 SUSPECT: raw=1 -> run_cnt+1; go BLOCKED when run_cnt+1 = THRESH; raw=0 -> IDLE, run_cnt=0.
REQ-018 Latency: first raw=1 cycle c0, raw held high -> block=1 from cycle c0+THRESH; THRESH=1 gives one-cycle registered latency.
REQ-019 block = 1 exactly while FSM in BLOCKED.
REQ-020 On each entry into BLOCKED: first_idx <= lowest i with axis_block_sigs[i] AND NOT axis_mask[i] in the entering cycle; event_count +1, saturating at all-ones.
REQ-021 Any single raw=0 cycle in SUSPECT restarts the run; no partial credit carried.
REQ-022 axis_mask changes take effect the same cycle in raw; masking the only blocked channel acts as raw=0.
REQ-023 clear=1: next state IDLE, run_cnt=0, block=0, first_idx=0, event_count=0; clear wins over simultaneous raw=1 and over BLOCKED entry.
REQ-024 Evaluation of raw resumes the cycle after clear deasserts.

Reset
REQ-025 reset_n=0 asynchronously forces IDLE, run_cnt=0, block=0, first_idx=0, event_count=0.
REQ-026 Reset assertion mid-SUSPECT or mid-BLOCKED discards all history; release resumes in IDLE on the next rising edge.

Configuration
REQ-027 Macro HLS_DEADLOCK_MONITOR_STICKY_EN defined: BLOCKED exits only via clear or reset; raw=0 ignored in BLOCKED.
REQ-028 Macro undefined: BLOCKED with raw=0 -> IDLE next cycle, run_cnt=0, block=0; first_idx and event_count retained.

Verification
REQ-029 THRESH=1, axis_block_sigs=3'b010 from cycle 5, inst_idle all 0 -> block=1 from cycle 6, first_idx=1, event_count=1.
REQ-030 THRESH=4, raw high cycles 10-12, low cycle 13, high 14-17 -> block=0 through 17, block=1 at cycle 18.
REQ-031 THRESH=2, axis_block_sigs=3'b101, axis_mask=3'b001 -> first_idx=2; axis_mask=3'b101 -> block never asserts.
REQ-032 inst_idle_sigs all 1 with axis_block_sigs=3'b111 -> block stays 0 indefinitely.
REQ-033 Non-sticky build: BLOCKED then raw low 1 cycle -> block=0 next cycle; sticky build: block stays 1 until clear=1, then 0 with event_count=0.
REQ-034 reset_n pulsed low mid-cycle while block=1 -> block=0 immediately (asynchronously), event_count=0; CNT_W=2 with 5 block events -> event_count=3.
